// File: rtl/wb_collector.sv
// Writeback collector: buffers results from four functional-unit sources in
// per-source FIFOs and drains them round-robin onto NR_WB_PORTS scoreboard
// write ports. Optional same-cycle bypass: define WB_COLLECTOR_BYPASS_EN.
module wb_collector #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned NR_WB_PORTS   = 2,
    parameter int unsigned DEPTH         = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             flush_i,
    input  logic [3:0]                       in_valid_i,
    input  logic [4*TRANS_ID_BITS-1:0]       in_trans_id_i,
    input  logic [4*XLEN-1:0]                in_result_i,
    input  logic [3:0]                       in_ex_valid_i,
    input  logic [4*XLEN-1:0]                in_ex_cause_i,
    input  logic                             wb_ready_i,
    output logic [NR_WB_PORTS-1:0]           wb_valid_o,
    output logic [NR_WB_PORTS*TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [NR_WB_PORTS*XLEN-1:0]      wb_result_o,
    output logic [NR_WB_PORTS-1:0]           wb_ex_valid_o,
    output logic [NR_WB_PORTS*XLEN-1:0]      wb_ex_cause_o,
    output logic                             overflow_o,
    output logic                             pending_o
);

    localparam int unsigned NSRC = 4;
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [XLEN-1:0]          result;
        logic                     ex_valid;
        logic [XLEN-1:0]          ex_cause;
    } entry_t;

    entry_t          mem_q    [NSRC][DEPTH];
    logic [PW-1:0]   rd_ptr_q [NSRC];
    logic [PW-1:0]   wr_ptr_q [NSRC];
    logic [CW-1:0]   cnt_q    [NSRC];
    logic [1:0]      rr_q;
    logic            overflow_q;

    entry_t          in_entry [NSRC];
    entry_t          head     [NSRC];
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] taken;
    logic [NSRC-1:0] pop;
    logic [NSRC-1:0] push;
    logic [NSRC-1:0] drop;
    logic [NSRC-1:0] bypass_take;
    logic [NR_WB_PORTS-1:0] port_vld;
    logic [1:0]      port_src [NR_WB_PORTS];
    logic [1:0]      last_grant;
    logic            deq_any;

    // Unpack flat per-source input buses into entries
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            in_entry[s].trans_id = in_trans_id_i[s*TRANS_ID_BITS +: TRANS_ID_BITS];
            in_entry[s].result   = in_result_i[s*XLEN +: XLEN];
            in_entry[s].ex_valid = in_ex_valid_i[s];
            in_entry[s].ex_cause = in_ex_cause_i[s*XLEN +: XLEN];
        end
    end

    // FIFO heads and grant eligibility (optionally the live input when empty)
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            head[s]     = mem_q[s][rd_ptr_q[s]];
            eligible[s] = (cnt_q[s] != '0);
`ifdef WB_COLLECTOR_BYPASS_EN
            if (cnt_q[s] == '0) begin
                head[s]     = in_entry[s];
                eligible[s] = in_valid_i[s] && rst_ni;
            end
`endif
        end
    end

    // Round-robin selection of up to NR_WB_PORTS distinct sources from rr_q
    always_comb begin
        logic [1:0] src;
        src        = '0;
        taken      = '0;
        last_grant = rr_q;
        for (int k = 0; k < NR_WB_PORTS; k++) begin
            port_vld[k] = 1'b0;
            port_src[k] = '0;
            // Descending scan so the lowest offset from rr_q wins
            for (int i = NSRC - 1; i >= 0; i--) begin
                src = rr_q + 2'(i);
                if (eligible[src] && !taken[src]) begin
                    port_vld[k] = 1'b1;
                    port_src[k] = src;
                end
            end
            if (port_vld[k]) begin
                taken[port_src[k]] = 1'b1;
                last_grant         = port_src[k];
            end
        end
        deq_any = wb_ready_i && !flush_i && (|port_vld);
    end

    // Drive write ports from the granted heads; flush forces them idle
    always_comb begin
        wb_valid_o    = '0;
        wb_trans_id_o = '0;
        wb_result_o   = '0;
        wb_ex_valid_o = '0;
        wb_ex_cause_o = '0;
        for (int k = 0; k < NR_WB_PORTS; k++) begin
            if (port_vld[k] && !flush_i) begin
                wb_valid_o[k]                                  = 1'b1;
                wb_trans_id_o[k*TRANS_ID_BITS +: TRANS_ID_BITS] = head[port_src[k]].trans_id;
                wb_result_o[k*XLEN +: XLEN]                    = head[port_src[k]].result;
                wb_ex_valid_o[k]                               = head[port_src[k]].ex_valid;
                wb_ex_cause_o[k*XLEN +: XLEN]                  = head[port_src[k]].ex_cause;
            end
        end
    end

    // Per-source push/pop/drop decisions; a full FIFO accepts if it pops
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            bypass_take[s] = 1'b0;
            pop[s]         = taken[s] && wb_ready_i && !flush_i && (cnt_q[s] != '0);
`ifdef WB_COLLECTOR_BYPASS_EN
            bypass_take[s] = taken[s] && wb_ready_i && !flush_i && (cnt_q[s] == '0);
`endif
            push[s] = in_valid_i[s] && !flush_i && !bypass_take[s]
                      && ((cnt_q[s] != CW'(DEPTH)) || pop[s]);
            drop[s] = in_valid_i[s] && !flush_i && !bypass_take[s]
                      && (cnt_q[s] == CW'(DEPTH)) && !pop[s];
        end
    end

    // Pointer, count, round-robin and sticky overflow state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            overflow_q <= 1'b0;
            for (int s = 0; s < NSRC; s++) begin
                rd_ptr_q[s] <= '0;
                wr_ptr_q[s] <= '0;
                cnt_q[s]    <= '0;
            end
        end else if (flush_i) begin
            rr_q       <= '0;
            overflow_q <= 1'b0;
            for (int s = 0; s < NSRC; s++) begin
                rd_ptr_q[s] <= '0;
                wr_ptr_q[s] <= '0;
                cnt_q[s]    <= '0;
            end
        end else begin
            if (deq_any) begin
                rr_q <= last_grant + 2'd1;
            end
            if (|drop) begin
                overflow_q <= 1'b1;
            end
            for (int s = 0; s < NSRC; s++) begin
                if (pop[s]) begin
                    rd_ptr_q[s] <= rd_ptr_q[s] + PW'(1);
                end
                if (push[s]) begin
                    wr_ptr_q[s] <= wr_ptr_q[s] + PW'(1);
                end
                cnt_q[s] <= cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
            end
        end
    end

    // FIFO storage; contents are don't-care while the count is zero
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < NSRC; s++) begin
            if (push[s]) begin
                mem_q[s][wr_ptr_q[s]] <= in_entry[s];
            end
        end
    end

    // Status outputs
    always_comb begin
        overflow_o = overflow_q;
        pending_o  = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            if (cnt_q[s] != '0) begin
                pending_o = 1'b1;
            end
        end
    end

endmodule

// File: doc/wb_collector.md
WB_COLLECTOR -- requirements
Module: wb_collector

Interface
REQ-001 SHALL have parameter: XLEN, 64, result and exception-cause width.
REQ-002 SHALL have parameter: TRANS_ID_BITS, 3, scoreboard transaction-ID width.
REQ-003 SHALL have parameter: NR_WB_PORTS, 2, scoreboard write ports (1..4).
REQ-004 SHALL have parameter: DEPTH, 2, per-source FIFO depth (power of two, >=2).
REQ-005 SHALL have ports (name, direction, width, meaning), clock and reset first:
 clk_i  in  1  clock;
 rst_ni  in  1  reset, asynchronous, active-low;
 flush_i  in  1  pipeline flush;
 in_valid_i  in  4  source valid (0=FLU, 1=load, 2=store, 3=FPU), no backpressure;
 in_trans_id_i  in  4*TRANS_ID_BITS  per-source scoreboard ID;
 in_result_i  in  4*XLEN  per-source result;
 in_ex_valid_i  in  4  per-source exception flag;
 in_ex_cause_i  in  4*XLEN  per-source exception cause;
 wb_ready_i  in  1  scoreboard accepts all write ports this cycle;
 wb_valid_o  out  NR_WB_PORTS  write-port valid;
 wb_trans_id_o  out  NR_WB_PORTS*TRANS_ID_BITS  write-port ID;
 wb_result_o  out  NR_WB_PORTS*XLEN  write-port result;
 wb_ex_valid_o  out  NR_WB_PORTS  write-port exception flag;
 wb_ex_cause_o  out  NR_WB_PORTS*XLEN  write-port cause;
 overflow_o  out  1  sticky drop indicator;
 pending_o  out  1  any FIFO non-empty.

Function
REQ-006 SHALL hold one FIFO per source (4 total), each DEPTH entries of {trans_id, result, ex_valid, ex_cause}.
REQ-007 SHALL enqueue a source's entry at the rising edge when in_valid_i is set, unless dropped per REQ-012.
REQ-008 SHALL each cycle grant up to NR_WB_PORTS distinct non-empty sources, scanned round-robin from pointer rr_q; grant k drives write port k; unused ports have valid 0.
REQ-009 SHALL drive write ports combinationally from FIFO heads; latency input->wb_valid_o is 1 cycle.
REQ-010 SHALL dequeue granted heads only when wb_ready_i=1; with wb_ready_i=0 outputs hold unchanged and rr_q holds.
REQ-011 SHALL advance rr_q to (last granted source + 1) mod 4 on a dequeue; unchanged when nothing granted.
REQ-012 SHALL drop an input whose FIFO is full and not dequeued that cycle, and set overflow_o at the next edge; full with simultaneous dequeue SHALL accept the input.
REQ-013 SHALL preserve per-source order; no ordering guarantee across sources.
REQ-014 SHALL force wb_valid_o=0 during flush_i, empty all FIFOs, reset rr_q to 0, clear overflow_o, and discard same-cycle inputs.
REQ-015 SHALL pass ex_valid/ex_cause unmodified with their entry; result is written even when ex_valid=1.
REQ-016 SHALL assert pending_o combinationally when any FIFO count is non-zero.
REQ-017 SHALL wrap FIFO read/write pointers modulo DEPTH with a separate count of width $clog2(DEPTH)+1.

Reset
REQ-018 SHALL, on rst_ni low, asynchronously empty all FIFOs, set rr_q=0, overflow_o=0, wb_valid_o=0, pending_o=0; reset mid-transfer SHALL drop all entries.

Configuration
REQ-019 SHALL provide macro WB_COLLECTOR_BYPASS_EN: when defined, a valid input arriving at an empty source FIFO is eligible for grant in the same cycle (latency 0); when granted and wb_ready_i=1 it is not enqueued, otherwise it is enqueued normally. When undefined, behaviour is strictly REQ-009 (latency 1) and no input-to-output combinational path exists.

Verification
REQ-020 SHALL cover: single FLU input ID=5, result 0xAB -> wb_valid_o[0]=1, ID 5, result 0xAB exactly one cycle later (bypass off), same cycle (bypass on).
REQ-021 SHALL cover: all 4 sources valid once, wb_ready_i=1, NR_WB_PORTS=2 -> cycle+1 grants sources 0,1; cycle+2 grants 2,3; rr_q returns to 0.
REQ-022 SHALL cover: wb_ready_i=0 for 3 cycles with FLU valid each cycle, DEPTH=2 -> third input dropped, overflow_o=1, outputs stable; flush clears overflow_o.
REQ-023 SHALL cover: load FIFO full, wb_ready_i=1 and new load valid same cycle -> input accepted, no overflow, order preserved.
REQ-024 SHALL cover: flush_i asserted with 3 entries pending and a same-cycle store input -> next cycle pending_o=0, wb_valid_o=0.
REQ-025 SHALL cover: FPU input ex_valid=1, cause 0x2 -> output ex_valid=1, cause 0x2, ID intact; rst_ni pulsed mid-stream -> all outputs 0 immediately.
